freq_ratio_meter: RTL and testbench

Measures an incoming divided clock against the system clock and reports its period and high time in system-clock cycles. It is the checking end of the frequency-divider blocks: it takes a divider output back in, verifies the divide ratio, and flags lock or loss of signal. It sits beside the divider in the clocking subsystem and feeds status registers and self-test logic.

---
 rtl/freq_meas_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 43 ++++
 rtl/freq_ratio_meter.sv | 117 +++++++++++
 tb/tb_freq_ratio_meter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// Shared definitions for the divided-clock period/high-time meter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package freq_meas_pkg;

    // Default build: 8-bit counters, two-flop synchronizer, four repeat periods to lock.
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_COUNT  = 4;

    // State codes kept as plain constants so older code that compares raw bits still works.
    localparam logic [0:0] ST_SEEK = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

    typedef enum logic [0:0] {
        SEEK = ST_SEEK,
        MEAS = ST_MEAS
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level and produces a registered rising-edge strobe.
// Latency: input sampled at edge k gives rise=1 after edge k+SYNC_STAGES.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, rst_n : clock and async active-low reset
//   sig        : asynchronous input level
//   lvl        : synchronized level, time-aligned with rise
//   rise       : one-cycle strobe on a synchronized 0->1 transition
module sync_edge_det
    import freq_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // rise is registered, so prev_q (not the raw synchronizer output) is the level
    // that lines up with it; consumers counting high cycles must use lvl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign lvl  = prev_q;
    assign rise = rise_q;

endmodule

// File: rtl/freq_ratio_meter.sv
// Measures period and high time of a divided clock in clk cycles; flags lock and loss of signal.
// Latency: sig_in rise sampled at edge k updates outputs / pulses valid_o at edge k+SYNC_STAGES+1.
// Backpressure: none; valid_o and timeout_o are single-cycle pulses with no handshake.
//
// Ports:
//   clk, rst_n : clock and async active-low reset
//   sig_in     : measured clock, asynchronous to clk
//   period_o   : last rise-to-rise period in clk cycles
//   high_o     : synchronized-high cycles within that period
//   valid_o    : pulse when period_o/high_o update
//   locked_o   : level, LOCK_COUNT repeats of the same period seen
//   timeout_o  : pulse, no rise within 2^CNT_W-1 cycles
module freq_ratio_meter
    import freq_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   hcnt_q;
    logic [CNT_W-1:0]   last_period_q;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_nxt;
    logic               sig_lvl;
    logic               rise;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig_in),
        .lvl   (sig_lvl),
        .rise  (rise)
    );

    // Match counter value to commit if this cycle closes a period. last_period_q
    // starts at 0, which no real period (>=2) can equal, so the first period never counts.
    always_comb begin
        match_nxt = '0;
        if (cnt_q == last_period_q) begin
            match_nxt = (match_q == MATCH_FULL) ? match_q : match_q + MATCH_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEEK;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            last_period_q <= '0;
            match_q       <= '0;
            period_o      <= '0;
            high_o        <= '0;
            valid_o       <= 1'b0;
            locked_o      <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state_q)
                SEEK: begin
                    // First edge only opens a measurement window; nothing to report yet.
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        hcnt_q  <= CNT_ONE;
                        state_q <= MEAS;
                    end
                end
                MEAS: begin
                    // rise is checked before the max-count test so a period of exactly
                    // CNT_MAX is reported rather than treated as a lost signal.
                    if (rise) begin
                        period_o      <= cnt_q;
                        high_o        <= hcnt_q;
                        valid_o       <= 1'b1;
                        cnt_q         <= CNT_ONE;
                        hcnt_q        <= CNT_ONE;
                        match_q       <= match_nxt;
                        last_period_q <= cnt_q;
                        locked_o      <= (match_nxt == MATCH_FULL);
                    end else if (cnt_q == CNT_MAX) begin
                        // Counters stop here, so they can never wrap.
                        timeout_o     <= 1'b1;
                        state_q       <= SEEK;
                        match_q       <= '0;
                        last_period_q <= '0;
                        locked_o      <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        hcnt_q <= hcnt_q + CNT_W'(sig_lvl);
                    end
                end
                default: state_q <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_ratio_meter.sv
// Self-checking bench for freq_ratio_meter against an input-timeline reference model.
// Latency: model events are delayed SYNC_STAGES+1 cycles before being compared.
// Backpressure: n/a.
module tb_freq_ratio_meter;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_COUNT  = 4;
    localparam int MAXP        = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             locked_o;
    logic             timeout_o;

    freq_ratio_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_COUNT  (LOCK_COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .locked_o  (locked_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Works on the sampled input: a period is the distance between two sampled
    // 0->1 transitions; high time counts sampled highs from one rise up to the next.
    // Resulting events surface at the outputs SYNC_STAGES+1 edges later.
    typedef struct {
        bit valid;
        bit timeout;
        int period;
        int high;
        bit locked;
    } ev_t;

    ev_t              pipe[$];
    ev_t              ev;
    ev_t              ev_out;
    bit               seeking;
    bit               prev_v;
    int               cyc;
    int               start;
    int               hsum;
    int               last_p;
    int               match;
    logic [CNT_W-1:0] m_period = '0;
    logic [CNT_W-1:0] m_high   = '0;
    logic             m_valid  = 1'b0;
    logic             m_timeout = 1'b0;
    logic             m_locked = 1'b0;

    wire [2*CNT_W+2:0] m_out   = {m_valid, m_timeout, m_locked, m_period, m_high};
    wire [2*CNT_W+2:0] dut_out = {valid_o, timeout_o, locked_o, period_o, high_o};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeking = 1'b1; prev_v = 1'b0; cyc = 0; start = 0; hsum = 0;
            last_p = 0; match = 0;
            m_period = '0; m_high = '0; m_valid = 1'b0; m_timeout = 1'b0; m_locked = 1'b0;
            pipe.delete();
            ev = '{default: 0};
            for (int i = 0; i < SYNC_STAGES + 1; i++) pipe.push_back(ev);
        end else begin
            ev = '{default: 0};
            if (sig_in && !prev_v) begin
                if (!seeking) begin
                    ev.valid  = 1'b1;
                    ev.period = cyc - start;
                    ev.high   = hsum;
                    if (cyc - start == last_p) match = (match < LOCK_COUNT) ? match + 1 : match;
                    else match = 0;
                    last_p    = cyc - start;
                    ev.locked = (match == LOCK_COUNT);
                end
                seeking = 1'b0;
                start   = cyc;
                hsum    = 1;
            end else if (!seeking) begin
                if (cyc - start == MAXP) begin
                    ev.timeout = 1'b1;
                    seeking    = 1'b1;
                    match      = 0;
                    last_p     = 0;
                end else if (sig_in) begin
                    hsum = hsum + 1;
                end
            end
            prev_v = sig_in;
            cyc    = cyc + 1;
            pipe.push_back(ev);
            ev_out    = pipe.pop_front();
            m_valid   = ev_out.valid;
            m_timeout = ev_out.timeout;
            if (ev_out.valid) begin
                m_period = CNT_W'(ev_out.period);
                m_high   = CNT_W'(ev_out.high);
                m_locked = ev_out.locked;
            end
            if (ev_out.timeout) m_locked = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit stim[$];

    task automatic do_reset();
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_pat(input int period, input int high, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < period; i++) stim.push_back(i < high);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_out !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", dut_out);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %h want 0", j, dut_out);
            end
        end
    endtask

    task automatic test_pattern_110();
        int first = -1;
        int nval = 0;
        int lock_at = -1;
        do_reset();
        stim.delete();
        push_pat(3, 2, 20);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL p110_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o) begin
                nval++;
                if (first < 0) first = j;
                if (locked_o && lock_at < 0) lock_at = nval;
                checks++;
                if (period_o !== CNT_W'(3) || high_o !== CNT_W'(2)) begin
                    errors++;
                    $display("FAIL p110_value got p%0d h%0d want p3 h2", period_o, high_o);
                end
            end
        end
        checks++;
        if (first != SYNC_STAGES + 1 + 3) begin
            errors++;
            $display("FAIL p110_first_valid got %0d want %0d", first, SYNC_STAGES + 4);
        end
        checks++;
        if (lock_at != LOCK_COUNT + 1) begin
            errors++;
            $display("FAIL p110_lock_index got %0d want %0d", lock_at, LOCK_COUNT + 1);
        end
    endtask

    // sig_in toggles every 1.5 clk cycles: changes on both clock phases.
    task automatic test_div3();
        int h = $urandom_range(0, 5);
        do_reset();
        for (int j = 0; j < 90; j++) begin
            sig_in = (h % 6 < 3) ? 1'b1 : 1'b0;
            h++;
            @(posedge clk);
            #1 sig_in = (h % 6 < 3) ? 1'b1 : 1'b0;
            h++;
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL div3_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o) begin
                checks++;
                if (period_o !== CNT_W'(3) || (high_o !== CNT_W'(1) && high_o !== CNT_W'(2))) begin
                    errors++;
                    $display("FAIL div3_value got p%0d h%0d want p3 h1or2", period_o, high_o);
                end
            end
        end
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL div3_locked got %b want 1", locked_o);
        end
    endtask

    task automatic test_ratio_change();
        int split;
        int n5 = 0;
        int relock = -1;
        do_reset();
        stim.delete();
        push_pat(3, 2, 8);
        split = stim.size();
        push_pat(5, 2, 8);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL change_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (j == split - 1) begin
                checks++;
                if (locked_o !== 1'b1) begin
                    errors++;
                    $display("FAIL change_prelock got %b want 1", locked_o);
                end
            end
            if (valid_o && period_o == CNT_W'(5)) begin
                n5++;
                if (n5 == 1) begin
                    checks++;
                    if (locked_o !== 1'b0 || high_o !== CNT_W'(2)) begin
                        errors++;
                        $display("FAIL change_unlock got l%b h%0d want l0 h2", locked_o, high_o);
                    end
                end
                if (locked_o && relock < 0) relock = n5;
            end
        end
        checks++;
        if (relock != LOCK_COUNT + 1) begin
            errors++;
            $display("FAIL change_relock got %0d want %0d", relock, LOCK_COUNT + 1);
        end
    endtask

    task automatic test_timeout();
        int last_v = -1;
        int t_at = -1;
        int n_to = 0;
        do_reset();
        stim.delete();
        push_pat(3, 2, 8);
        for (int i = 0; i < 300; i++) stim.push_back(1'b0);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL timeout_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o) last_v = j;
            if (timeout_o) begin
                n_to++;
                t_at = j;
            end
        end
        checks++;
        if (n_to != 1 || t_at - last_v != MAXP) begin
            errors++;
            $display("FAIL timeout_pulse got n%0d dist%0d want n1 dist%0d", n_to, t_at - last_v, MAXP);
        end
        checks++;
        if (locked_o !== 1'b0 || period_o !== CNT_W'(3)) begin
            errors++;
            $display("FAIL timeout_hold got l%b p%0d want l0 p3", locked_o, period_o);
        end
    endtask

    // Starts in SEEK (after the timeout test): two periods of 255, then one of 256.
    task automatic test_boundary();
        int n255 = 0;
        int nval = 0;
        int n_to_a = 0;
        int n_to_b = 0;
        int split;
        stim.delete();
        push_pat(MAXP, 1, 2);
        stim.push_back(1'b1);
        split = stim.size() + SYNC_STAGES + 1;
        for (int i = 0; i < MAXP + 1 - 1; i++) stim.push_back(1'b0);
        stim.push_back(1'b1);
        for (int i = 0; i < 20; i++) stim.push_back(1'b0);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL boundary_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o) nval++;
            if (valid_o && period_o == CNT_W'(MAXP)) n255++;
            if (timeout_o) begin
                if (j < split) n_to_a++;
                else n_to_b++;
            end
        end
        checks++;
        if (n255 != 2 || n_to_a != 0) begin
            errors++;
            $display("FAIL boundary_255 got v%0d t%0d want v2 t0", n255, n_to_a);
        end
        checks++;
        if (n_to_b != 1 || nval != 2) begin
            errors++;
            $display("FAIL boundary_256 got t%0d v%0d want t1 v2", n_to_b, nval);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        do_reset();
        stim.delete();
        push_pat(3, 2, 8);
        stim.push_back(1'b1);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
        end
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_prelock got %b want 1", locked_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== '0) begin
            errors++;
            $display("FAIL rstmid_async got %h want 0", dut_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        push_pat(3, 2, 5);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL rstmid_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o && first < 0) first = j;
        end
        checks++;
        if (first != SYNC_STAGES + 1 + 3) begin
            errors++;
            $display("FAIL rstmid_first_valid got %0d want %0d", first, SYNC_STAGES + 4);
        end
    endtask

    task automatic test_random();
        int p;
        int nval = 0;
        do_reset();
        stim.delete();
        for (int s = 0; s < 14; s++) begin
            p = $urandom_range(2, 20);
            push_pat(p, $urandom_range(1, p - 1), $urandom_range(2, 8));
        end
        p = $urandom_range(240, 262);
        push_pat(p, $urandom_range(1, 100), 3);
        push_pat(4, 1, 6);
        for (int j = 0; j < stim.size(); j++) begin
            sig_in = stim[j];
            @(negedge clk);
            checks++;
            if (dut_out !== m_out) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h want %h", j, dut_out, m_out);
            end
            if (valid_o) nval++;
        end
        checks++;
        if (nval < 20) begin
            errors++;
            $display("FAIL random_activity got %0d valids want >=20", nval);
        end
    endtask

    initial begin
        test_reset();
        test_pattern_110();
        test_div3();
        test_ratio_change();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
